// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller driving the core's INT input.
// Rising edges on irq_in are latched into a pending register. A software mask
// blocks individual sources. The lowest-index pending, unmasked source is
// offered to the core, which completes a req/ack/done handshake for it.
// Optional feature macro: INT_ACK_TIMEOUT_EN. When it is defined, a request
// that is not acknowledged within ACK_TIMEOUT cycles is withdrawn and arbitrated
// again.
module int_ctrl #(
    parameter int NSRC        = 8,
    parameter int IDW         = 3,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_in,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_din,
    input  logic            int_ack,
    input  logic            int_done,
    output logic            INT,
    output logic [IDW-1:0]  int_id,
    output logic [NSRC-1:0] pending,
    output logic            busy
);

    // Reject configurations that cannot be encoded or cannot time out.
    if ((1 << IDW) < NSRC) begin : g_bad_idw
        $error("int_ctrl: IDW too small for NSRC");
    end
    if (ACK_TIMEOUT < 1) begin : g_bad_timeout
        $error("int_ctrl: ACK_TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t          state_r;
    logic [NSRC-1:0] irq_q_r;
    logic [NSRC-1:0] mask_r;
    logic [NSRC-1:0] pending_r;
    logic            int_r;
    logic [IDW-1:0]  int_id_r;
    logic            busy_r;

    logic [NSRC-1:0] edge_s;
    logic [NSRC-1:0] clr_s;
    logic [NSRC-1:0] eligible_s;
    logic [IDW-1:0]  win_id_s;
    logic            win_valid_s;

`ifdef INT_ACK_TIMEOUT_EN
    localparam int CNTW = $clog2(ACK_TIMEOUT + 1);
    logic [CNTW-1:0] tmo_cnt_r;
`endif

    // Index of the lowest set bit; index 0 carries the highest priority.
    function automatic logic [IDW-1:0] lowest_idx(input logic [NSRC-1:0] v);
        logic [IDW-1:0] idx;
        idx = {IDW{1'b0}};
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Edge detection, pending clear on acknowledge, and arbitration.
    always_comb begin
        edge_s      = irq_in & ~irq_q_r;
        eligible_s  = pending_r & ~mask_r;
        win_valid_s = |eligible_s;
        win_id_s    = lowest_idx(eligible_s);
        if ((state_r == ST_REQ) && int_ack) begin
            clr_s = {{(NSRC-1){1'b0}}, 1'b1} << int_id_r;
        end else begin
            clr_s = {NSRC{1'b0}};
        end
    end

    // Input history for edge detection. The mask register takes effect on the
    // cycle after the write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q_r <= {NSRC{1'b0}};
            mask_r  <= {NSRC{1'b0}};
        end else begin
            irq_q_r <= irq_in;
            if (mask_we) begin
                mask_r <= mask_din;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    // Pending events. A new edge overrides a clear of the same bit, so no event
    // is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r <= {NSRC{1'b0}};
        end else begin
            pending_r <= (pending_r & ~clr_s) | edge_s;
        end
    end

    // Handshake FSM with registered INT, int_id and busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            int_r     <= 1'b0;
            int_id_r  <= {IDW{1'b0}};
            busy_r    <= 1'b0;
`ifdef INT_ACK_TIMEOUT_EN
            tmo_cnt_r <= {CNTW{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        int_id_r  <= win_id_s;
                        int_r     <= 1'b1;
                        state_r   <= ST_REQ;
`ifdef INT_ACK_TIMEOUT_EN
                        tmo_cnt_r <= {CNTW{1'b0}};
`endif
                    end else begin
                        int_r   <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        int_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_SERVICE;
`ifdef INT_ACK_TIMEOUT_EN
                    end else if (tmo_cnt_r == CNTW'(ACK_TIMEOUT - 1)) begin
                        // Withdraw the request; its pending bit stays set, so
                        // it is arbitrated again from IDLE.
                        int_r     <= 1'b0;
                        state_r   <= ST_IDLE;
                        tmo_cnt_r <= {CNTW{1'b0}};
                    end else begin
                        int_r     <= 1'b1;
                        tmo_cnt_r <= tmo_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
                    end
`else
                    end else begin
                        int_r <= 1'b1;
                    end
`endif
                end
                ST_SERVICE: begin
                    int_r <= 1'b0;
                    if (int_done) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    int_r    <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign INT     = int_r;
    assign int_id  = int_id_r;
    assign pending = pending_r;
    assign busy    = busy_r;

endmodule
